mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port memory/bus port between instruction fetch (IF) and the
//   execute unit's load/store path (EX). One outstanding transaction at a time.
//   EX has priority; a starvation guard ensures IF progress.
//   Produces the EX-side pipeline hold flag for ctrl. Sits between pc_reg/exu and mems.
// PARAMETERS
//   ADDR_WIDTH    32  address width of all ports
//   DATA_WIDTH    32  data width of all ports
//   STARVE_LIMIT  4   consecutive EX grants while IF waits before IF is forced; 0 = no guard
// PORTS
//   clk          in   1           clock
//   rst          in   1           synchronous reset, active-high
//   if_req_i     in   1           IF read request
//   if_addr_i    in   ADDR_WIDTH  IF read address
//   if_gnt_o     out  1           IF request accepted by memory
//   if_rvalid_o  out  1           IF read data valid
//   if_rdata_o   out  DATA_WIDTH  IF read data
//   ex_req_i     in   1           EX request
//   ex_we_i      in   1           EX write enable
//   ex_addr_i    in   ADDR_WIDTH  EX address
//   ex_wdata_i   in   DATA_WIDTH  EX write data
//   ex_be_i      in   DATA_WIDTH/8 EX byte enables
//   ex_gnt_o     out  1           EX request accepted
//   ex_rvalid_o  out  1           EX response (read data valid / write ack)
//   ex_rdata_o   out  DATA_WIDTH  EX read data
//   mem_req_o    out  1           memory request
//   mem_we_o     out  1           memory write enable
//   mem_addr_o   out  ADDR_WIDTH  memory address
//   mem_wdata_o  out  DATA_WIDTH  memory write data
//   mem_be_o     out  DATA_WIDTH/8 memory byte enables (all-ones for IF)
//   mem_gnt_i    in   1           memory accepted request this cycle
//   mem_rvalid_i in   1           memory response (reads and writes)
//   mem_rdata_i  in   DATA_WIDTH  memory read data
//   hold_flag_o  out  1           stall request to ctrl while EX access incomplete
// BEHAVIOUR
//   States: IDLE, ISSUE, WAIT_RSP. Registers: owner (IF/EX), ex_streak counter.
//   IDLE: if any req, pick winner -> owner, go ISSUE next cycle. Winner = EX if ex_req_i,
//     unless STARVE_LIMIT!=0 and ex_streak==STARVE_LIMIT and if_req_i -> IF.
//   ISSUE: mem_req_o=1, mem_* driven from owner's inputs. Owner is locked; no re-arbitration
//     until mem_gnt_i. On mem_gnt_i: pulse owner's gnt_o (same cycle), go WAIT_RSP.
//   WAIT_RSP: mem_req_o=0. On mem_rvalid_i: pulse owner's rvalid_o, rdata_o=mem_rdata_i
//     (combinational pass-through), go IDLE. Min 3 cycles req-to-response; new arb next cycle.
//   ex_streak: on EX gnt with if_req_i high -> +1 (saturate at STARVE_LIMIT); on IF gnt -> 0;
//     on EX gnt with if_req_i low -> 0.
//   Requesters hold req/addr/data stable until their gnt_o; a req dropped before gnt in
//     ISSUE is still completed (response delivered, ignored upstream).
//   hold_flag_o = (ex_req_i & ~(owner==EX & state!=IDLE)) | (owner==EX & state!=IDLE),
//     deasserted in the cycle ex_rvalid_o is high.
//   mem_rvalid_i outside WAIT_RSP is discarded (no rvalid_o pulse).
//   Reset: state=IDLE, owner=IF, ex_streak=0; all outputs 0 during rst cycle, even if
//     req inputs high. Reset mid-transaction abandons it; late response is discarded.
//   rdata_o of non-owner driven 0. mem_be_o=all-ones for IF; mem_we_o=0 for IF.
// TESTING
//   1 IF-only read 0x100, mem gnt immediate, rvalid 1 cycle later data 0xDEADBEEF ->
//     if_gnt_o @ISSUE, if_rvalid_o=1 if_rdata_o=0xDEADBEEF, hold_flag_o=0 throughout.
//   2 IF and EX request same cycle (EX write 0x2000<-0x55AA, be=4'b0011) -> EX issued first,
//     mem_we_o=1 mem_be_o=0011; IF issued after EX rvalid; hold_flag_o high until EX rvalid.
//   3 EX req continuously + IF req held, STARVE_LIMIT=4 -> 4 EX grants, 5th grant to IF,
//     then ex_streak=0; STARVE_LIMIT=0 -> IF never granted while EX requests.
//   4 mem_gnt_i low 5 cycles in ISSUE(IF), EX req arrives -> mem_addr_o stays IF address,
//     no switch; EX granted only after IF response.
//   5 rst asserted in WAIT_RSP(EX), mem_rvalid_i arrives cycle after rst drops -> no
//     ex_rvalid_o, all outputs 0 during rst, state IDLE.
//   6 Spurious mem_rvalid_i in IDLE -> no rvalid_o pulse to either requester.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the three handshake groups around mem_port_arbiter:
//     - IF read port   : if_req_i/if_addr_i -> if_gnt_o/if_rvalid_o/if_rdata_o
//     - EX load/store  : ex_req_i/ex_we_i/ex_addr_i/ex_wdata_i/ex_be_i
//                        -> ex_gnt_o/ex_rvalid_o/ex_rdata_o
//     - memory port    : mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o
//                        <- mem_gnt_i/mem_rvalid_i/mem_rdata_i
//     - hold_flag_o    : EX-side pipeline stall towards ctrl
//   Signal suffixes are written from the arbiter's point of view.
//   Modports:
//     slave  - the arbiter itself
//     master - the surrounding environment (requesters, memory, ctrl)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // IF read port
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [DATA_WIDTH-1:0] if_rdata_o;

    // EX load/store port
    logic                  ex_req_i;
    logic                  ex_we_i;
    logic [ADDR_WIDTH-1:0] ex_addr_i;
    logic [DATA_WIDTH-1:0] ex_wdata_i;
    logic [BE_WIDTH-1:0]   ex_be_i;
    logic                  ex_gnt_o;
    logic                  ex_rvalid_o;
    logic [DATA_WIDTH-1:0] ex_rdata_o;

    // Shared memory port
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    // Stall towards ctrl
    logic                  hold_flag_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i, ex_be_i,
        output ex_gnt_o, ex_rvalid_o, ex_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output hold_flag_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i, ex_be_i,
        input  ex_gnt_o, ex_rvalid_o, ex_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  hold_flag_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and the
//   execute unit's load/store path (EX), one outstanding transaction at a
//   time. EX wins arbitration unless IF has been passed over STARVE_LIMIT
//   times in a row while waiting (STARVE_LIMIT = 0 disables the guard).
//   Also produces hold_flag_o, the EX-side stall for ctrl.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous reset, active-high
//     bus  - mem_port_arbiter_if.slave (IF port, EX port, memory port,
//            hold_flag_o)
//
//   Transaction flow: IDLE (arbitrate) -> ISSUE (mem_req_o until mem_gnt_i)
//   -> WAIT_RSP (until mem_rvalid_i) -> IDLE.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             rst,
    mem_port_arbiter_if.slave bus
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    localparam bit GUARD_EN = (STARVE_LIMIT != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_EX
    } owner_e;

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;

    logic                  force_if;
    logic                  gnt_fire;
    logic                  rsp_fire;
    logic                  ex_busy;
    logic                  issue_act;
    logic [ADDR_WIDTH-1:0] owner_addr;

    // IF is forced only when it is actually waiting and EX has used up its streak.
    assign force_if = GUARD_EN && (streak_q == STREAK_MAX) && bus.if_req_i;

    assign gnt_fire = (state_q == ST_ISSUE)    && bus.mem_gnt_i;
    // Responses are only meaningful while a transaction is outstanding; any
    // other mem_rvalid_i (spurious, or late after a reset) is dropped here.
    assign rsp_fire = (state_q == ST_WAIT_RSP) && bus.mem_rvalid_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; a missing default here would infer latches.
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.if_req_i || bus.ex_req_i) begin
                    owner_d = (bus.ex_req_i && !force_if) ? OWN_EX : OWN_IF;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // Owner stays locked until the memory accepts the request.
                if (bus.mem_gnt_i) begin
                    state_d = ST_WAIT_RSP;
                    if (owner_q == OWN_EX && bus.if_req_i) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q
                                                            : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end
            end

            ST_WAIT_RSP: begin
                if (bus.mem_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state, with the handshake pulses and
    // read data passed straight through. Everything is forced low while
    // rst is high, even mid-transaction.
    // ------------------------------------------------------------------
    assign ex_busy    = (owner_q == OWN_EX) && (state_q != ST_IDLE);
    assign issue_act  = !rst && (state_q == ST_ISSUE);
    assign owner_addr = (owner_q == OWN_EX) ? bus.ex_addr_i : bus.if_addr_i;

    assign bus.mem_req_o   = issue_act;
    assign bus.mem_we_o    = issue_act && (owner_q == OWN_EX) && bus.ex_we_i;
    assign bus.mem_addr_o  = issue_act ? owner_addr : '0;
    assign bus.mem_wdata_o = (issue_act && owner_q == OWN_EX) ? bus.ex_wdata_i : '0;
    assign bus.mem_be_o    = !issue_act          ? '0 :
                             (owner_q == OWN_EX) ? bus.ex_be_i : {BE_WIDTH{1'b1}};

    assign bus.if_gnt_o    = !rst && gnt_fire && (owner_q == OWN_IF);
    assign bus.ex_gnt_o    = !rst && gnt_fire && (owner_q == OWN_EX);
    assign bus.if_rvalid_o = !rst && rsp_fire && (owner_q == OWN_IF);
    assign bus.ex_rvalid_o = !rst && rsp_fire && (owner_q == OWN_EX);
    assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;
    assign bus.ex_rdata_o  = bus.ex_rvalid_o ? bus.mem_rdata_i : '0;

    // EX is stalled while it waits for the port or its own access is in
    // flight; the stall lifts in the cycle its response arrives.
    assign bus.hold_flag_o = !rst && (bus.ex_req_i || ex_busy) && !bus.ex_rvalid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b2 ();

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(0)) dut_nog (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs are changed here and
    // outputs are sampled #1 later, well clear of either clock edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_b1();
        b1.if_req_i     = 1'b0;
        b1.if_addr_i    = '0;
        b1.ex_req_i     = 1'b0;
        b1.ex_we_i      = 1'b0;
        b1.ex_addr_i    = '0;
        b1.ex_wdata_i   = '0;
        b1.ex_be_i      = '0;
        b1.mem_gnt_i    = 1'b0;
        b1.mem_rvalid_i = 1'b0;
        b1.mem_rdata_i  = '0;
    endtask

    task automatic idle_b2();
        b2.if_req_i     = 1'b0;
        b2.if_addr_i    = '0;
        b2.ex_req_i     = 1'b0;
        b2.ex_we_i      = 1'b0;
        b2.ex_addr_i    = '0;
        b2.ex_wdata_i   = '0;
        b2.ex_be_i      = '0;
        b2.mem_gnt_i    = 1'b0;
        b2.mem_rvalid_i = 1'b0;
        b2.mem_rdata_i  = '0;
    endtask

    int   n_gnt;
    int   nog_if;
    int   nog_ex;
    logic seq_ex [0:7];
    logic exp_ex [0:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        idle_b1();
        idle_b2();

        // ---------------- reset with requests pending ----------------
        b1.if_req_i     = 1'b1;
        b1.ex_req_i     = 1'b1;
        b1.mem_gnt_i    = 1'b1;
        b1.mem_rvalid_i = 1'b1;
        step();
        step();
        #1;
        check("rst_mem_req",   32'(b1.mem_req_o),   32'd0);
        check("rst_hold",      32'(b1.hold_flag_o), 32'd0);
        check("rst_ex_gnt",    32'(b1.ex_gnt_o),    32'd0);
        check("rst_if_rvalid", 32'(b1.if_rvalid_o), 32'd0);

        step();
        rst = 1'b0;
        idle_b1();
        #1;
        check("post_rst_mem_req", 32'(b1.mem_req_o),   32'd0);
        check("post_rst_hold",    32'(b1.hold_flag_o), 32'd0);

        // ---------------- 1: IF-only read ----------------
        step();
        b1.if_req_i  = 1'b1;
        b1.if_addr_i = 32'h100;
        b1.mem_gnt_i = 1'b1;
        #1;
        check("t1_idle_mem_req", 32'(b1.mem_req_o),   32'd0);
        check("t1_idle_hold",    32'(b1.hold_flag_o), 32'd0);

        step();
        #1;
        check("t1_mem_req",  32'(b1.mem_req_o),   32'd1);
        check("t1_mem_addr", b1.mem_addr_o,       32'h100);
        check("t1_mem_we",   32'(b1.mem_we_o),    32'd0);
        check("t1_mem_be",   32'(b1.mem_be_o),    32'hF);
        check("t1_if_gnt",   32'(b1.if_gnt_o),    32'd1);
        check("t1_iss_hold", 32'(b1.hold_flag_o), 32'd0);

        step();
        b1.if_req_i     = 1'b0;
        b1.mem_gnt_i    = 1'b0;
        b1.mem_rvalid_i = 1'b1;
        b1.mem_rdata_i  = 32'hDEADBEEF;
        #1;
        check("t1_if_rvalid", 32'(b1.if_rvalid_o), 32'd1);
        check("t1_if_rdata",  b1.if_rdata_o,       32'hDEADBEEF);
        check("t1_ex_rvalid", 32'(b1.ex_rvalid_o), 32'd0);
        check("t1_ex_rdata",  b1.ex_rdata_o,       32'd0);
        check("t1_rsp_hold",  32'(b1.hold_flag_o), 32'd0);

        step();
        b1.mem_rvalid_i = 1'b0;
        #1;
        check("t1_done_if_rvalid", 32'(b1.if_rvalid_o), 32'd0);

        // ---------------- 2: IF and EX in the same cycle ----------------
        step();
        b1.if_req_i   = 1'b1;
        b1.if_addr_i  = 32'h104;
        b1.ex_req_i   = 1'b1;
        b1.ex_we_i    = 1'b1;
        b1.ex_addr_i  = 32'h2000;
        b1.ex_wdata_i = 32'h55AA;
        b1.ex_be_i    = 4'b0011;
        b1.mem_gnt_i  = 1'b1;
        #1;
        check("t2_idle_hold",    32'(b1.hold_flag_o), 32'd1);
        check("t2_idle_mem_req", 32'(b1.mem_req_o),   32'd0);

        step();
        #1;
        check("t2_ex_gnt",    32'(b1.ex_gnt_o),    32'd1);
        check("t2_if_gnt",    32'(b1.if_gnt_o),    32'd0);
        check("t2_mem_we",    32'(b1.mem_we_o),    32'd1);
        check("t2_mem_addr",  b1.mem_addr_o,       32'h2000);
        check("t2_mem_wdata", b1.mem_wdata_o,      32'h55AA);
        check("t2_mem_be",    32'(b1.mem_be_o),    32'h3);
        check("t2_iss_hold",  32'(b1.hold_flag_o), 32'd1);

        step();
        b1.ex_req_i  = 1'b0;
        b1.mem_gnt_i = 1'b0;
        #1;
        check("t2_wait_hold",      32'(b1.hold_flag_o), 32'd1);
        check("t2_wait_ex_rvalid", 32'(b1.ex_rvalid_o), 32'd0);

        step();
        b1.mem_rvalid_i = 1'b1;
        #1;
        check("t2_ex_rvalid", 32'(b1.ex_rvalid_o), 32'd1);
        check("t2_if_rvalid", 32'(b1.if_rvalid_o), 32'd0);
        check("t2_rsp_hold",  32'(b1.hold_flag_o), 32'd0);

        step();
        b1.mem_rvalid_i = 1'b0;
        b1.mem_gnt_i    = 1'b1;
        #1;
        check("t2_idle2_mem_req", 32'(b1.mem_req_o), 32'd0);

        step();
        #1;
        check("t2_if_gnt2",    32'(b1.if_gnt_o),    32'd1);
        check("t2_if_addr",    b1.mem_addr_o,       32'h104);
        check("t2_if_we",      32'(b1.mem_we_o),    32'd0);
        check("t2_if_be",      32'(b1.mem_be_o),    32'hF);

        step();
        b1.if_req_i     = 1'b0;
        b1.mem_gnt_i    = 1'b0;
        b1.mem_rvalid_i = 1'b1;
        b1.mem_rdata_i  = 32'h12345678;
        #1;
        check("t2_if_rdata", b1.if_rdata_o, 32'h12345678);

        step();
        idle_b1();
        #1;

        // ---------------- 3: starvation guard ----------------
        n_gnt  = 0;
        nog_if = 0;
        nog_ex = 0;
        for (int i = 0; i < 18; i++) begin
            step();
            if (i == 0) begin
                b1.if_req_i     = 1'b1;
                b1.if_addr_i    = 32'h200;
                b1.ex_req_i     = 1'b1;
                b1.ex_addr_i    = 32'h3000;
                b1.mem_gnt_i    = 1'b1;
                b1.mem_rvalid_i = 1'b1;
                b2.if_req_i     = 1'b1;
                b2.if_addr_i    = 32'h200;
                b2.ex_req_i     = 1'b1;
                b2.ex_addr_i    = 32'h3000;
                b2.mem_gnt_i    = 1'b1;
                b2.mem_rvalid_i = 1'b1;
            end
            #1;
            if (b1.ex_gnt_o || b1.if_gnt_o) begin
                if (n_gnt < 8) seq_ex[n_gnt] = b1.ex_gnt_o;
                n_gnt++;
            end
            if (b2.if_gnt_o) nog_if++;
            if (b2.ex_gnt_o) nog_ex++;
        end
        check("t3_grant_count", 32'(n_gnt), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_grant%0d_is_ex", i), 32'(seq_ex[i]), 32'(exp_ex[i]));
        end
        check("t3_noguard_if_grants", 32'(nog_if), 32'd0);
        check("t3_noguard_ex_grants", 32'(nog_ex), 32'd6);

        // ---------------- 4: IF locked in ISSUE while gnt is low ----------------
        step();
        idle_b1();
        idle_b2();
        b1.if_req_i  = 1'b1;
        b1.if_addr_i = 32'h300;
        #1;
        check("t4_idle_mem_req", 32'(b1.mem_req_o), 32'd0);

        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 1) begin
                b1.ex_req_i  = 1'b1;
                b1.ex_we_i   = 1'b0;
                b1.ex_addr_i = 32'h2004;
                b1.ex_be_i   = 4'b1100;
            end
            #1;
            check($sformatf("t4_stall%0d_addr", k), b1.mem_addr_o, 32'h300);
            check($sformatf("t4_stall%0d_ex_gnt", k), 32'(b1.ex_gnt_o), 32'd0);
        end

        step();
        b1.mem_gnt_i = 1'b1;
        #1;
        check("t4_if_gnt",   32'(b1.if_gnt_o),    32'd1);
        check("t4_ex_gnt",   32'(b1.ex_gnt_o),    32'd0);
        check("t4_mem_addr", b1.mem_addr_o,       32'h300);
        check("t4_hold",     32'(b1.hold_flag_o), 32'd1);

        step();
        b1.if_req_i     = 1'b0;
        b1.mem_gnt_i    = 1'b0;
        b1.mem_rvalid_i = 1'b1;
        b1.mem_rdata_i  = 32'hA5A5A5A5;
        #1;
        check("t4_if_rdata",  b1.if_rdata_o,       32'hA5A5A5A5);
        check("t4_ex_rvalid", 32'(b1.ex_rvalid_o), 32'd0);

        step();
        b1.mem_rvalid_i = 1'b0;
        b1.mem_gnt_i    = 1'b1;
        #1;
        check("t4_idle2_mem_req", 32'(b1.mem_req_o), 32'd0);

        step();
        #1;
        check("t4_ex_gnt2",   32'(b1.ex_gnt_o),  32'd1);
        check("t4_ex_addr",   b1.mem_addr_o,     32'h2004);
        check("t4_ex_be",     32'(b1.mem_be_o),  32'hC);

        step();
        b1.ex_req_i     = 1'b0;
        b1.mem_gnt_i    = 1'b0;
        b1.mem_rvalid_i = 1'b1;
        b1.mem_rdata_i  = 32'h0BADF00D;
        #1;
        check("t4_ex_rdata",    b1.ex_rdata_o,       32'h0BADF00D);
        check("t4_if_rdata_nz", b1.if_rdata_o,       32'd0);
        check("t4_rsp_hold",    32'(b1.hold_flag_o), 32'd0);

        step();
        b1.mem_rvalid_i = 1'b0;
        #1;

        // ---------------- 5: reset during EX WAIT_RSP ----------------
        step();
        b1.ex_req_i   = 1'b1;
        b1.ex_we_i    = 1'b1;
        b1.ex_addr_i  = 32'h2008;
        b1.ex_wdata_i = 32'h1111;
        b1.ex_be_i    = 4'hF;
        b1.mem_gnt_i  = 1'b1;
        #1;
        check("t5_idle_hold", 32'(b1.hold_flag_o), 32'd1);

        step();
        #1;
        check("t5_ex_gnt", 32'(b1.ex_gnt_o), 32'd1);

        step();
        b1.ex_req_i  = 1'b0;
        b1.mem_gnt_i = 1'b0;
        #1;
        check("t5_wait_hold", 32'(b1.hold_flag_o), 32'd1);

        step();
        rst             = 1'b1;
        b1.if_req_i     = 1'b1;
        b1.ex_req_i     = 1'b1;
        b1.mem_gnt_i    = 1'b1;
        b1.mem_rvalid_i = 1'b1;
        #1;
        check("t5_rst_ex_rvalid", 32'(b1.ex_rvalid_o), 32'd0);
        check("t5_rst_ex_rdata",  b1.ex_rdata_o,       32'd0);
        check("t5_rst_hold",      32'(b1.hold_flag_o), 32'd0);
        check("t5_rst_mem_req",   32'(b1.mem_req_o),   32'd0);
        check("t5_rst_mem_addr",  b1.mem_addr_o,       32'd0);

        step();
        rst          = 1'b0;
        b1.if_req_i  = 1'b0;
        b1.ex_req_i  = 1'b0;
        b1.mem_gnt_i = 1'b0;
        #1;
        check("t5_late_ex_rvalid", 32'(b1.ex_rvalid_o), 32'd0);
        check("t5_late_if_rvalid", 32'(b1.if_rvalid_o), 32'd0);
        check("t5_late_hold",      32'(b1.hold_flag_o), 32'd0);

        step();
        b1.mem_rvalid_i = 1'b0;
        b1.if_req_i     = 1'b1;
        b1.if_addr_i    = 32'h400;
        b1.mem_gnt_i    = 1'b1;
        #1;
        check("t5_idle_mem_req", 32'(b1.mem_req_o), 32'd0);

        step();
        #1;
        check("t5_if_gnt",   32'(b1.if_gnt_o), 32'd1);
        check("t5_mem_addr", b1.mem_addr_o,    32'h400);

        // ---------------- 6: spurious response in IDLE ----------------
        step();
        b1.if_req_i     = 1'b0;
        b1.mem_gnt_i    = 1'b0;
        b1.mem_rvalid_i = 1'b1;
        b1.mem_rdata_i  = 32'hCAFEF00D;
        #1;
        check("t6_real_if_rvalid", 32'(b1.if_rvalid_o), 32'd1);

        b1.mem_rdata_i = 32'h77777777;
        for (int k = 0; k < 2; k++) begin
            step();
            #1;
            check($sformatf("t6_spur%0d_if_rvalid", k), 32'(b1.if_rvalid_o), 32'd0);
            check($sformatf("t6_spur%0d_ex_rvalid", k), 32'(b1.ex_rvalid_o), 32'd0);
            check($sformatf("t6_spur%0d_if_rdata", k),  b1.if_rdata_o,       32'd0);
        end

        step();
        idle_b1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
